blackjack_hand: RTL and testbench

BLACKJACK_HAND -- requirements
Module: blackjack_hand

---
 rtl/blackjack_hand_pkg.sv | 33 +++
 rtl/blackjack_hand_if.sv | 21 ++
 rtl/blackjack_hand_bin2dec_2digit.sv | 32 +++
 rtl/blackjack_hand.sv | 151 +++++++++++++++
 tb/tb_blackjack_hand.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/blackjack_hand_pkg.sv
// Shared types and constants for the blackjack hand scorer.
// Holds the FSM states, display glyph codes and card values.
package blackjack_hand_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        ADJ,
        BUST,
        BJ,
        STOOD
    } state_t;

    localparam logic [3:0] BLANK     = 4'd15;
    localparam logic [3:0] GLY_BUST  = 4'd10;
    localparam logic [3:0] GLY_BJ    = 4'd11;
    localparam logic [3:0] GLY_STAND = 4'd12;
    localparam logic [3:0] GLY_FULL  = 4'd13;

    localparam logic [5:0] ACE_VAL  = 6'd11;
    localparam logic [5:0] FACE_VAL = 6'd10;
    localparam logic [5:0] SOFT_ADJ = 6'd10;

    function automatic logic [5:0] card_value(input logic [3:0] r);
        if (r == 4'd1)
            return ACE_VAL;
        else if (r >= 4'd11)
            return FACE_VAL;
        else
            return {2'b00, r};
    endfunction

endpackage

// File: rtl/blackjack_hand_if.sv
// Card offer handshake between the dealer side and the hand scorer.
// The dealer drives valid/rank; the scorer answers with ready.
interface blackjack_hand_if;

    logic       card_valid;
    logic [3:0] card_rank;
    logic       card_ready;

    modport master (
        output card_valid,
        output card_rank,
        input  card_ready
    );

    modport slave (
        input  card_valid,
        input  card_rank,
        output card_ready
    );

endinterface

// File: rtl/blackjack_hand_bin2dec_2digit.sv
// Binary (0..31) to two decimal digit codes by compare-and-subtract.
// Optionally blanks a leading zero tens digit.
module bin2dec_2digit
    import blackjack_hand_pkg::*;
(
    input  logic [4:0] bin,
    input  logic       blank_lead,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [4:0] sub;

    always_comb begin
        tens = 4'd0;
        sub  = 5'd0;
        if (bin >= 5'd30) begin
            tens = 4'd3;
            sub  = 5'd30;
        end else if (bin >= 5'd20) begin
            tens = 4'd2;
            sub  = 5'd20;
        end else if (bin >= 5'd10) begin
            tens = 4'd1;
            sub  = 5'd10;
        end
        ones = 4'(bin - sub);
        if (blank_lead && tens == 4'd0)
            tens = BLANK;
    end

endmodule

// File: rtl/blackjack_hand.sv
// Blackjack hand scorer: accepts cards, tracks soft aces,
// and drives registered seven-segment digit codes.
module blackjack_hand
    import blackjack_hand_pkg::*;
#(
    parameter int MAX_CARDS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_hand,
    input  logic             stand,
    blackjack_hand_if.slave  card,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [4:0]       total,
    output logic             err
);

    localparam logic [3:0] MAXC = 4'(MAX_CARDS);

    state_t     state, state_n;
    logic [5:0] acc, acc_n;
    logic [3:0] count, count_n;
    logic [3:0] soft_aces, soft_n;
    logic [3:0] last_rank, last_n;
    logic       err_n;
    logic       accept, legal;
    logic [3:0] status;
    logic [3:0] tot_t, tot_o, rk_t, rk_o;

    assign card.card_ready = (state == PLAY) && (count < MAXC);
    // stand and new_hand both outrank a card offered in the same cycle
    assign accept = card.card_valid && card.card_ready
                    && !stand && !new_hand;
    assign legal  = (card.card_rank >= 4'd1)
                    && (card.card_rank <= 4'd13);
    assign total  = (acc > 6'd31) ? 5'd31 : acc[4:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            soft_aces <= '0;
            last_rank <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            count     <= count_n;
            soft_aces <= soft_n;
            last_rank <= last_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        soft_n  = soft_aces;
        last_n  = last_rank;
        err_n   = err;
        unique case (state)
            PLAY: begin
                if (stand) begin
                    state_n = STOOD;
                end else if (accept && legal) begin
                    acc_n   = acc + card_value(card.card_rank);
                    count_n = count + 4'd1;
                    last_n  = card.card_rank;
                    state_n = ADJ;
                    if (card.card_rank == 4'd1)
                        soft_n = soft_aces + 4'd1;
                end else if (accept) begin
                    err_n = 1'b1;
                end
            end
            ADJ: begin
                // one soft ace demoted per cycle until none applies
                if (acc > 6'd21 && soft_aces != 4'd0) begin
                    acc_n  = acc - SOFT_ADJ;
                    soft_n = soft_aces - 4'd1;
                end else if (acc > 6'd21) begin
                    state_n = BUST;
                end else if (acc == 6'd21 && count == 4'd2) begin
                    state_n = BJ;
                end else begin
                    state_n = PLAY;
                end
            end
            default: ;
        endcase
        if (new_hand) begin
            state_n = PLAY;
            acc_n   = '0;
            count_n = '0;
            soft_n  = '0;
            last_n  = '0;
            err_n   = 1'b0;
        end
    end

    always_comb begin
        status = BLANK;
        unique case (state)
            BUST:    status = GLY_BUST;
            BJ:      status = GLY_BJ;
            STOOD:   status = GLY_STAND;
            PLAY:    if (count == MAXC) status = GLY_FULL;
            default: ;
        endcase
    end

    bin2dec_2digit u_tot (
        .bin        (total),
        .blank_lead (1'b1),
        .tens       (tot_t),
        .ones       (tot_o)
    );

    bin2dec_2digit u_rank (
        .bin        ({1'b0, last_rank}),
        .blank_lead (1'b1),
        .tens       (rk_t),
        .ones       (rk_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0 <= BLANK;
            d1 <= BLANK;
            d2 <= BLANK;
            d3 <= BLANK;
            d4 <= BLANK;
            d5 <= BLANK;
        end else begin
            d0 <= tot_o;
            d1 <= tot_t;
            d2 <= (count == 4'd0) ? BLANK : rk_o;
            d3 <= (count == 4'd0) ? BLANK : rk_t;
            d4 <= count;
            d5 <= status;
        end
    end

endmodule

// File: tb/tb_blackjack_hand.sv
// Directed bench for blackjack_hand with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_blackjack_hand;
    import blackjack_hand_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_hand = 1'b0;
    logic stand = 1'b0;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [4:0] total;
    logic err;
    int vectors = 0;
    int miscompares = 0;

    blackjack_hand_if bus ();

    blackjack_hand #(.MAX_CARDS(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_hand (new_hand),
        .stand    (stand),
        .card     (bus),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .total    (total),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (dut.state != ADJ) break;
            tick();
        end
        check(tag, 32'(dut.state == ADJ), 32'd0);
        tick();
    endtask

    task automatic deal(input logic [3:0] r);
        bus.card_valid = 1'b1;
        bus.card_rank  = r;
        tick();
        bus.card_valid = 1'b0;
        settle("adj_exit");
    endtask

    task automatic start_hand();
        new_hand = 1'b1;
        tick();
        new_hand = 1'b0;
    endtask

    initial begin
        bus.card_valid = 1'b0;
        bus.card_rank  = 4'd0;

        tick();
        tick();
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_ready", 32'(bus.card_ready), 32'd0);
        check("rst_total", 32'(total), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_digits", {8'd0, d5, d4, d3, d2, d1, d0}, 32'hFFFFFF);

        rst = 1'b0;
        tick();
        tick();
        check("idle_hold", 32'(dut.state), 32'(IDLE));
        check("idle_ready", 32'(bus.card_ready), 32'd0);

        start_hand();
        check("nh_state", 32'(dut.state), 32'(PLAY));
        check("nh_ready", 32'(bus.card_ready), 32'd1);

        deal(4'd1);
        check("bj_t1", 32'(total), 32'd11);
        deal(4'd13);
        check("bj_total", 32'(total), 32'd21);
        check("bj_count", 32'(dut.count), 32'd2);
        check("bj_state", 32'(dut.state), 32'(BJ));
        check("bj_d5", 32'(d5), 32'd11);
        check("bj_d1d0", {24'd0, d1, d0}, 32'h21);
        check("bj_ready", 32'(bus.card_ready), 32'd0);

        start_hand();
        deal(4'd1);
        check("soft_t1", 32'(total), 32'd11);
        deal(4'd1);
        check("soft_t2", 32'(total), 32'd12);
        check("soft_aces2", 32'(dut.soft_aces), 32'd1);
        deal(4'd9);
        check("soft_t3", 32'(total), 32'd21);
        check("soft_state", 32'(dut.state), 32'(PLAY));
        check("soft_d5", 32'(d5), 32'd15);

        start_hand();
        deal(4'd10);
        deal(4'd6);
        check("bust_t2", 32'(total), 32'd16);
        deal(4'd12);
        check("bust_total", 32'(total), 32'd26);
        check("bust_state", 32'(dut.state), 32'(BUST));
        check("bust_d5", 32'(d5), 32'd10);
        check("bust_d3d2", {24'd0, d3, d2}, 32'h12);
        check("bust_ready", 32'(bus.card_ready), 32'd0);
        bus.card_valid = 1'b1;
        bus.card_rank  = 4'd5;
        tick();
        tick();
        bus.card_valid = 1'b0;
        check("bust_count", 32'(dut.count), 32'd3);
        check("bust_hold", 32'(total), 32'd26);

        start_hand();
        deal(4'd5);
        deal(4'd14);
        check("ill_err", 32'(err), 32'd1);
        check("ill_total", 32'(total), 32'd5);
        check("ill_state", 32'(dut.state), 32'(PLAY));
        check("ill_d1d0", {24'd0, d1, d0}, 32'hF5);
        check("ill_d3d2", {24'd0, d3, d2}, 32'hF5);
        stand = 1'b1;
        bus.card_valid = 1'b1;
        bus.card_rank  = 4'd3;
        tick();
        stand = 1'b0;
        bus.card_valid = 1'b0;
        tick();
        check("st_state", 32'(dut.state), 32'(STOOD));
        check("st_d5", 32'(d5), 32'd12);
        check("st_count", 32'(dut.count), 32'd1);
        check("st_d4", 32'(d4), 32'd1);
        check("st_total", 32'(total), 32'd5);
        check("st_err", 32'(err), 32'd1);

        start_hand();
        check("lim_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 9; i++) deal(4'd2);
        check("lim_total", 32'(total), 32'd18);
        check("lim_d4", 32'(d4), 32'd9);
        check("lim_d5", 32'(d5), 32'd13);
        check("lim_ready", 32'(bus.card_ready), 32'd0);

        start_hand();
        deal(4'd10);
        deal(4'd6);
        bus.card_valid = 1'b1;
        bus.card_rank  = 4'd9;
        tick();
        bus.card_valid = 1'b0;
        check("mid_adj", 32'(dut.state), 32'(ADJ));
        rst = 1'b1;
        #1;
        check("mr_state", 32'(dut.state), 32'(IDLE));
        check("mr_total", 32'(total), 32'd0);
        check("mr_ready", 32'(bus.card_ready), 32'd0);
        check("mr_digits", {8'd0, d5, d4, d3, d2, d1, d0}, 32'hFFFFFF);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mr_idle", 32'(dut.state), 32'(IDLE));
        start_hand();
        tick();
        check("mr_nh_state", 32'(dut.state), 32'(PLAY));
        check("mr_nh_total", 32'(total), 32'd0);
        check("mr_nh_d4", 32'(d4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
